// File: rtl/ot_pkg.sv
// Shared definitions for the OT block RAM path.
//   OT_BLOCK_W : width of one OT block / RAM word
//   OT_ADDR_W  : RAM address width (depth = 2**OT_ADDR_W)
//   ot_block_t : one OT block
//   ld_state_e : loader FSM states
package ot_pkg;

  localparam int OT_BLOCK_W = 128;
  localparam int OT_ADDR_W  = 6;

  typedef logic [OT_BLOCK_W-1:0] ot_block_t;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_LOAD  = 2'd1,
    LD_FLUSH = 2'd2,
    LD_DONE  = 2'd3
  } ld_state_e;

endpackage

// File: rtl/ot_bram_loader.sv
// Write-side front end for the OT block RAM. Accepts a valid/ready stream
// of OT blocks and writes `len` words to consecutive (wrapping) addresses
// starting at `base_addr`, through a single registered write stage.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, base_addr, len   load request; base/len sampled with start in IDLE
//   abort                   synchronous cancel (ignored in IDLE)
//   in_data/in_valid/in_ready   incoming OT block stream
//   ram_data/ram_waddr/ram_wr_en  RAM write port
//   busy                    high in LOAD and FLUSH
//   done                    one-cycle pulse once every word is committed
//   words_written           words committed in the current or last load
module ot_bram_loader
  import ot_pkg::*;
#(
  parameter int DATA_WIDTH = OT_BLOCK_W,
  parameter int ADDR_WIDTH = OT_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic                  ram_wr_en,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_written
);

  ld_state_e               r_state;
  ld_state_e               w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_ptr;
  logic [ADDR_WIDTH:0]     r_remaining;
  logic [ADDR_WIDTH:0]     r_words;
  logic [DATA_WIDTH-1:0]   r_ram_data_p1;
  logic [ADDR_WIDTH-1:0]   r_ram_waddr_p1;
  logic                    r_vld_p1;
  logic                    w_in_ready;
  logic                    w_busy;
  logic                    w_done;
  logic                    w_beat;
  logic                    w_last_beat;
  logic                    w_load_start;

  assign w_load_start = (r_state == LD_IDLE) && start;
  assign w_beat       = in_valid && w_in_ready;
  assign w_last_beat  = w_beat && (r_remaining == (ADDR_WIDTH+1)'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LD_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort is only meaningful outside IDLE, so start wins there
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LD_IDLE: begin
        if (start) begin
          w_state_nxt = (len != '0) ? LD_LOAD : LD_DONE;
        end
      end
      LD_LOAD: begin
        if (abort) begin
          w_state_nxt = LD_IDLE;
        end else if (w_last_beat) begin
          w_state_nxt = LD_FLUSH;
        end
      end
      LD_FLUSH: w_state_nxt = abort ? LD_IDLE : LD_DONE;
      LD_DONE:  w_state_nxt = LD_IDLE;
      default:  w_state_nxt = LD_IDLE;
    endcase
  end

  // Outputs; in_ready never looks at in_valid
  always_comb begin
    w_in_ready = (r_state == LD_LOAD) && (r_remaining != '0) && !abort;
    w_busy     = (r_state == LD_LOAD) || (r_state == LD_FLUSH);
    w_done     = (r_state == LD_DONE) && !abort;
  end

  // Address pointer and beat budget, latched on start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_remaining <= '0;
    end else if (w_load_start) begin
      r_ptr       <= base_addr;
      r_remaining <= len;
    end else if (w_beat) begin
      r_ptr       <= r_ptr + ADDR_WIDTH'(1);
      r_remaining <= r_remaining - (ADDR_WIDTH+1)'(1);
    end
  end

  // ---- stage p1: registered RAM write; data/address hold when idle ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1       <= 1'b0;
      r_ram_data_p1  <= '0;
      r_ram_waddr_p1 <= '0;
    end else begin
      r_vld_p1 <= w_beat;
      if (w_beat) begin
        r_ram_data_p1  <= in_data;
        r_ram_waddr_p1 <= r_ptr;
      end
    end
  end

  // Count commits as they reach the RAM, so an abort still counts the
  // write that was already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_words <= '0;
    end else if (w_load_start) begin
      r_words <= '0;
    end else if (r_vld_p1) begin
      r_words <= r_words + (ADDR_WIDTH+1)'(1);
    end
  end

  assign in_ready      = w_in_ready;
  assign busy          = w_busy;
  assign done          = w_done;
  assign ram_wr_en     = r_vld_p1;
  assign ram_data      = r_ram_data_p1;
  assign ram_waddr     = r_ram_waddr_p1;
  assign words_written = r_words;

endmodule

// File: doc/ot_bram_loader.md
Name: ot_bram_loader

Overview:
- Write-side front end for the 128-bit OT block RAM: takes a valid/ready stream of OT blocks (PRG/AES output) and writes a programmed number of words into consecutive RAM addresses starting at a programmed base.
- Drives only the RAM write port (data_in, write_addr, wr_en); the read port belongs to the downstream consumer.
- Reports progress and a completion pulse timed so that every written word is committed in RAM when done is seen.

Parameters:
- DATA_WIDTH, 128, width of one OT block / RAM word
- ADDR_WIDTH, 6, RAM address width; depth = 2**ADDR_WIDTH

Ports:
- clk  input  1  single clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a load; honoured only in IDLE
- base_addr  input  ADDR_WIDTH  first RAM address; sampled with start
- len  input  ADDR_WIDTH+1  number of words, 0..2**ADDR_WIDTH; sampled with start
- abort  input  1  synchronous cancel of the current load
- in_data  input  DATA_WIDTH  incoming OT block
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts in_data this cycle
- ram_data  output  DATA_WIDTH  to RAM data_in
- ram_waddr  output  ADDR_WIDTH  to RAM write_addr
- ram_wr_en  output  1  to RAM wr_en
- busy  output  1  high in LOAD and FLUSH
- done  output  1  one-cycle pulse when the load completes
- words_written  output  ADDR_WIDTH+1  number of words committed in the current or last load

Behaviour:
- Reset (async, rst_n low): state IDLE; in_ready=0, ram_wr_en=0, ram_data=0, ram_waddr=0, busy=0, done=0, words_written=0.
- FSM states: IDLE, LOAD, FLUSH, DONE.
  - IDLE: on start, latch base_addr into the pointer and len into remaining, clear words_written. Go to LOAD if len>0, otherwise go to DONE.
  - LOAD: in_ready = (remaining != 0). A beat is accepted when in_valid and in_ready are both high. On the beat that makes remaining 0, go to FLUSH.
  - FLUSH: one cycle; the final write is presented to the RAM. Then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Write pipeline is one registered stage. A beat accepted in cycle N produces, in cycle N+1: ram_wr_en=1, ram_data=in_data(N), ram_waddr=pointer(N). The pointer increments after each beat.
- In cycles with no accepted beat, ram_wr_en=0 and ram_data/ram_waddr hold their last values.
- words_written increments in every cycle where ram_wr_en=1.
- Timing: last beat accepted in cycle N, last write presented in N+1, done in N+2. At done, words_written == len.
- len=0: start in cycle N gives done in cycle N+1, with no writes and in_ready never asserted.
- Address wrap-around: the pointer is ADDR_WIDTH bits and wraps modulo 2**ADDR_WIDTH. Example: base=62, len=4 writes addresses 62, 63, 0, 1.
- len=2**ADDR_WIDTH fills the whole RAM once; the final address is base-1 (mod depth).
- in_valid low mid-load: no write, state holds. Stalls of any length are allowed.
- start while not IDLE: ignored, with no effect on latched values.
- abort (any state except IDLE): in_ready=0 in the same cycle. A write already registered from the previous cycle still completes. The FSM then goes to IDLE with no done pulse, and words_written keeps its count.
- abort and start in the same cycle in IDLE: start wins; abort is ignored in IDLE.
- rst_n low mid-load: immediate return to reset values. The write in flight is dropped (ram_wr_en=0 asynchronously).
- Combinational paths: in_ready depends only on registered state and abort; it never depends on in_valid.

Decomposition:
- Shared package ot_pkg:
  - OT_BLOCK_W=128, OT_ADDR_W=6
  - loader FSM state enum
  - typedef ot_block_t = logic [OT_BLOCK_W-1:0]
- No sub-module needed. The registered write stage and the FSM sit in one module of roughly 150 lines.

Test Plan:
- Basic load: start base=0, len=4, in_valid held high with data 0xA0..0xA3.
  - Required: ram_wr_en in 4 consecutive cycles at addresses 0..3 with the matching data.
  - Required: done pulses 2 cycles after the 4th beat; words_written=4.
- Wrap-around: base=62, len=4, data 1..4.
  - Required: writes at 62, 63, 0, 1; a read-back of the BRAM instance returns 1..4 at those addresses.
- Backpressure/stall: len=3, in_valid toggled 1,0,0,1,0,1.
  - Required: exactly 3 writes, each 1 cycle after its accepted beat; no write in stall cycles.
- Zero and full length:
  - len=0: done the cycle after start and no ram_wr_en.
  - len=64, base=5: 64 writes ending at address 4; words_written=64.
- Abort mid-load: len=10, abort asserted after 3 accepted beats.
  - Required: in_ready drops that cycle, 3 writes total, no done, busy=0 next cycle, words_written=3.
- Reset mid-load and ignored start:
  - rst_n pulsed low during LOAD: all outputs return to 0 immediately.
  - start during LOAD: latched base/len unchanged.
